// File: rtl/pomdp_state_sampler_if.sv
`default_nettype none
// ============================================================================
// Module  : pomdp_state_sampler_if
// Brief   : Request/result bundle between the action selector, the sampler and
//           the belief-update stage.
// Revision: 1.0 - initial release
// ============================================================================
interface pomdp_state_sampler_if #(
    parameter int N_STATES  = 4,
    parameter int N_ACTIONS = 3,
    parameter int PW        = 16,
    parameter int RW        = 16
);
    localparam int SW = (N_STATES  > 1) ? $clog2(N_STATES)  : 1;
    localparam int AW = (N_ACTIONS > 1) ? $clog2(N_ACTIONS) : 1;

    logic          start_i;
    logic [SW-1:0] cur_state_i;
    logic [AW-1:0] action_i;
    logic [PW-1:0] random_i;
    logic          out_ready_i;
    logic          busy_o;
    logic          out_valid_o;
    logic [SW-1:0] new_state_o;
    logic [RW-1:0] out_reward_o;
    logic          err_o;
    logic          residual_o;

    modport master (
        output start_i, cur_state_i, action_i, random_i, out_ready_i,
        input  busy_o, out_valid_o, new_state_o, out_reward_o, err_o, residual_o
    );

    modport slave (
        input  start_i, cur_state_i, action_i, random_i, out_ready_i,
        output busy_o, out_valid_o, new_state_o, out_reward_o, err_o, residual_o
    );
endinterface
`default_nettype wire

// File: rtl/pomdp_state_sampler.sv
`default_nettype none
// ============================================================================
// Module  : pomdp_state_sampler
// Brief   : Draws a successor state by walking the cumulative transition row
//           one entry per cycle; also returns the immediate reward.
// Revision: 1.0 - initial release
// ============================================================================
module pomdp_state_sampler #(
    parameter int N_STATES  = 4,
    parameter int N_ACTIONS = 3,
    parameter int PW        = 16,
    parameter int RW        = 16
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic [N_ACTIONS-1:0][N_STATES-1:0][RW-1:0]      vec_reward_i,
    input  logic [N_ACTIONS-1:0][N_STATES-1:0][N_STATES-1:0][PW-1:0] trans_i,
    pomdp_state_sampler_if.slave                            bus
);
    localparam int SW   = (N_STATES  > 1) ? $clog2(N_STATES)  : 1;
    localparam int AW   = (N_ACTIONS > 1) ? $clog2(N_ACTIONS) : 1;
    localparam int ACCW = PW + SW;
    localparam logic [SW-1:0] c_LAST = SW'(N_STATES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [AW-1:0]   a_q, a_d;
    logic [PW-1:0]   rnd_q, rnd_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [SW-1:0]   j_q, j_d;
    logic            ill_q, ill_d;
    logic [SW-1:0]   new_state_q, new_state_d;
    logic [RW-1:0]   reward_q, reward_d;
    logic            err_q, err_d;
    logic            residual_q, residual_d;

    logic [ACCW-1:0] w_acc_next;
    logic            w_hit;
    logic            w_illegal;

    assign w_acc_next = acc_q + ACCW'(trans_i[a_q][s_q][j_q]);
    assign w_hit      = ACCW'(rnd_q) < w_acc_next;
    assign w_illegal  = ({1'b0, bus.cur_state_i} >= (SW+1)'(N_STATES)) ||
                        ({1'b0, bus.action_i}    >= (AW+1)'(N_ACTIONS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            a_q         <= '0;
            rnd_q       <= '0;
            acc_q       <= '0;
            j_q         <= '0;
            ill_q       <= 1'b0;
            new_state_q <= '0;
            reward_q    <= '0;
            err_q       <= 1'b0;
            residual_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            a_q         <= a_d;
            rnd_q       <= rnd_d;
            acc_q       <= acc_d;
            j_q         <= j_d;
            ill_q       <= ill_d;
            new_state_q <= new_state_d;
            reward_q    <= reward_d;
            err_q       <= err_d;
            residual_q  <= residual_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        a_d         = a_q;
        rnd_d       = rnd_q;
        acc_d       = acc_q;
        j_d         = j_q;
        ill_d       = ill_q;
        new_state_d = new_state_q;
        reward_d    = reward_q;
        err_d       = err_q;
        residual_d  = residual_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    s_d     = bus.cur_state_i;
                    a_d     = bus.action_i;
                    rnd_d   = bus.random_i;
                    acc_d   = '0;
                    j_d     = '0;
                    ill_d   = w_illegal;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // Illegal requests spend one SCAN cycle so they report with fixed latency.
                if (ill_q) begin
                    new_state_d = '0;
                    reward_d    = '0;
                    err_d       = 1'b1;
                    residual_d  = 1'b0;
                    state_d     = ST_DONE;
                end else if (w_hit) begin
                    new_state_d = j_q;
                    reward_d    = vec_reward_i[a_q][s_q];
                    err_d       = 1'b0;
                    residual_d  = 1'b0;
                    state_d     = ST_DONE;
                end else if (j_q == c_LAST) begin
                    new_state_d = c_LAST;
                    reward_d    = vec_reward_i[a_q][s_q];
                    err_d       = 1'b0;
                    residual_d  = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    j_d   = j_q + SW'(1);
                    acc_d = w_acc_next;
                end
            end
            ST_DONE: begin
                if (bus.out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.busy_o       = (state_q != ST_IDLE);
    assign bus.out_valid_o  = (state_q == ST_DONE);
    assign bus.new_state_o  = new_state_q;
    assign bus.out_reward_o = reward_q;
    assign bus.err_o        = err_q;
    assign bus.residual_o   = residual_q;

endmodule
`default_nettype wire

// File: tb/tb_pomdp_state_sampler.sv
`default_nettype none
// ============================================================================
// Module  : tb_pomdp_state_sampler
// Brief   : Self-checking bench for pomdp_state_sampler.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pomdp_state_sampler;
    localparam int NS = 4;
    localparam int NA = 3;
    localparam int PW = 16;
    localparam int RW = 16;
    localparam int SW = 2;
    localparam int AW = 2;
    localparam int NV = 13;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NA-1:0][NS-1:0][RW-1:0]         vec_reward;
    logic [NA-1:0][NS-1:0][NS-1:0][PW-1:0] trans;

    pomdp_state_sampler_if #(.N_STATES(NS), .N_ACTIONS(NA), .PW(PW), .RW(RW)) bus ();

    pomdp_state_sampler #(.N_STATES(NS), .N_ACTIONS(NA), .PW(PW), .RW(RW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vec_reward_i (vec_reward),
        .trans_i      (trans),
        .bus          (bus)
    );

    typedef struct {
        logic [AW-1:0] act;
        logic [SW-1:0] cs;
        logic [PW-1:0] rnd;
        logic [SW-1:0] ns;
        logic [RW-1:0] rw;
        logic          err;
        logic          res;
        int            lat;
    } vec_t;

    vec_t vecs [NV];
    vec_t sb_q [$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [AW-1:0] a, input logic [SW-1:0] s,
                         input logic [PW-1:0] r, input logic st);
        bus.action_i    = a;
        bus.cur_state_i = s;
        bus.random_i    = r;
        bus.start_i     = st;
    endtask

    // Counts edges from the accepting edge (edge 1) until out_valid is seen.
    task automatic wait_valid(output int edges, output bit seen);
        edges = 1;
        seen  = bus.out_valid_o;
        while (!seen && edges < 20) begin
            @(posedge clk);
            edges++;
            #1;
            seen = bus.out_valid_o;
        end
    endtask

    task automatic compare_result(input string tag, input int edges, input bit seen);
        vec_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_scoreboard: got empty queue, expected an entry", tag);
            return;
        end
        e = sb_q.pop_front();
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got no out_valid in %0d edges, expected edge %0d", tag, edges, e.lat);
            return;
        end
        chk({tag, "_new_state"}, 32'(bus.new_state_o),  32'(e.ns));
        chk({tag, "_reward"},    32'(bus.out_reward_o), 32'(e.rw));
        chk({tag, "_err"},       32'(bus.err_o),        32'(e.err));
        chk({tag, "_residual"},  32'(bus.residual_o),   32'(e.res));
        chk({tag, "_latency"},   32'(edges),            32'(e.lat));
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int    edges;
        bit    seen;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        drive(v.act, v.cs, v.rnd, 1'b1);
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        sb_q.push_back(v);
        #1;
        bus.start_i = 1'b0;
        chk({tag, "_busy_accept"}, 32'(bus.busy_o), 32'd1);
        wait_valid(edges, seen);
        compare_result(tag, edges, seen);
        if (seen) begin
            @(posedge clk);
            #1;
            chk({tag, "_busy_after"},  32'(bus.busy_o),      32'd0);
            chk({tag, "_valid_after"}, 32'(bus.out_valid_o), 32'd0);
        end
    endtask

    initial begin
        int   edges;
        bit   seen;
        vec_t e;

        trans = '0;
        for (int a = 0; a < NA; a++)
            for (int s = 0; s < NS; s++)
                vec_reward[a][s] = RW'(32'hA000 + a * 256 + s * 16);
        vec_reward[1][2] = 16'h0123;
        for (int j = 0; j < NS; j++) begin
            trans[1][2][j] = 16'h4000;
            trans[0][3][j] = 16'h2000;
        end
        trans[0][1][1] = 16'h8000;
        trans[0][1][3] = 16'h8000;
        trans[2][0][0] = 16'hC000;
        trans[2][0][1] = 16'hC000;

        vecs[0]  = '{2'd1, 2'd2, 16'h0000, 2'd0, 16'h0123, 1'b0, 1'b0, 2};
        vecs[1]  = '{2'd1, 2'd2, 16'h3FFF, 2'd0, 16'h0123, 1'b0, 1'b0, 2};
        vecs[2]  = '{2'd1, 2'd2, 16'h4000, 2'd1, 16'h0123, 1'b0, 1'b0, 3};
        vecs[3]  = '{2'd1, 2'd2, 16'hBFFF, 2'd2, 16'h0123, 1'b0, 1'b0, 4};
        vecs[4]  = '{2'd1, 2'd2, 16'hC000, 2'd3, 16'h0123, 1'b0, 1'b0, 5};
        vecs[5]  = '{2'd1, 2'd2, 16'hFFFF, 2'd3, 16'h0123, 1'b0, 1'b0, 5};
        vecs[6]  = '{2'd0, 2'd3, 16'h9000, 2'd3, 16'hA030, 1'b0, 1'b1, 5};
        vecs[7]  = '{2'd0, 2'd3, 16'h7FFF, 2'd3, 16'hA030, 1'b0, 1'b0, 5};
        vecs[8]  = '{2'd3, 2'd2, 16'h1234, 2'd0, 16'h0000, 1'b1, 1'b0, 2};
        vecs[9]  = '{2'd0, 2'd1, 16'h0000, 2'd1, 16'hA010, 1'b0, 1'b0, 3};
        vecs[10] = '{2'd0, 2'd1, 16'h8000, 2'd3, 16'hA010, 1'b0, 1'b0, 5};
        vecs[11] = '{2'd2, 2'd0, 16'hF000, 2'd1, 16'hA200, 1'b0, 1'b0, 3};
        vecs[12] = '{2'd2, 2'd0, 16'hBFFF, 2'd0, 16'hA200, 1'b0, 1'b0, 2};

        drive('0, '0, '0, 1'b0);
        bus.out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",      32'(bus.busy_o),       32'd0);
        chk("rst_valid",     32'(bus.out_valid_o),  32'd0);
        chk("rst_new_state", 32'(bus.new_state_o),  32'd0);
        chk("rst_reward",    32'(bus.out_reward_o), 32'd0);
        chk("rst_err",       32'(bus.err_o),        32'd0);
        chk("rst_residual",  32'(bus.residual_o),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Backpressure, with conflicting start pulses during SCAN, DONE and the handshake cycle.
        @(negedge clk);
        drive(2'd1, 2'd2, 16'hBFFF, 1'b1);
        bus.out_ready_i = 1'b0;
        @(posedge clk);
        e = '{2'd1, 2'd2, 16'hBFFF, 2'd2, 16'h0123, 1'b0, 1'b0, 4};
        sb_q.push_back(e);
        #1;
        drive(2'd0, 2'd1, 16'h0000, 1'b1);
        wait_valid(edges, seen);
        compare_result("bp", edges, seen);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d_valid", k),  32'(bus.out_valid_o),  32'd1);
            chk($sformatf("bp_hold%0d_state", k),  32'(bus.new_state_o),  32'd2);
            chk($sformatf("bp_hold%0d_reward", k), 32'(bus.out_reward_o), 32'h0123);
            chk($sformatf("bp_hold%0d_busy", k),   32'(bus.busy_o),       32'd1);
        end
        @(negedge clk);
        drive(2'd1, 2'd2, 16'h0000, 1'b1);
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        chk("hs_busy",       32'(bus.busy_o),      32'd0);
        chk("hs_valid",      32'(bus.out_valid_o), 32'd0);
        chk("idle_hold_new", 32'(bus.new_state_o), 32'd2);
        @(posedge clk);
        #1;
        chk("hs_start_ignored", 32'(bus.busy_o), 32'd0);

        // Reset in the middle of a scan, then a full-latency restart.
        @(negedge clk);
        drive(2'd1, 2'd2, 16'hFFFF, 1'b1);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        @(posedge clk);
        #2;
        chk("pre_rst_busy", 32'(bus.busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",      32'(bus.busy_o),       32'd0);
        chk("mid_rst_valid",     32'(bus.out_valid_o),  32'd0);
        chk("mid_rst_new_state", 32'(bus.new_state_o),  32'd0);
        chk("mid_rst_reward",    32'(bus.out_reward_o), 32'd0);
        chk("mid_rst_err",       32'(bus.err_o),        32'd0);
        chk("mid_rst_residual",  32'(bus.residual_o),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        e = '{2'd1, 2'd2, 16'hC000, 2'd3, 16'h0123, 1'b0, 1'b0, 5};
        run_vec(e, 99);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
